// File: rtl/fpu_operand_loader.sv
// Assembles 9-byte serial frames (header, A, B MSB-first) into an operand set for the FP adder.
// op_valid 1 cycle after last B byte; in_ready drops while the set is held awaiting op_ready.
module fpu_operand_loader #(
    parameter logic [3:0]  SYNC    = 4'hA,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        op_valid,
    input  logic        op_ready,
    output logic [31:0] op_a,
    output logic [31:0] op_b,
    output logic [1:0]  op_round,
    output logic        op_special,
    output logic        frame_err
);

    typedef enum logic [1:0] {IDLE, LOAD_A, LOAD_B, HOLD} state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [7:0]  to_q, to_d;
    logic [31:0] op_a_q, op_a_d;
    logic [31:0] op_b_q, op_b_d;
    logic [1:0]  round_q, round_d;
    logic        special_q, special_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;
    logic        accept;
    logic [31:0] b_shift;

    assign in_ready = !rst && (state_q != HOLD);
    assign accept   = in_valid && in_ready;
    assign b_shift  = {op_b_q[23:0], in_data};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        to_d      = to_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        round_d   = round_q;
        special_d = special_q;
        valid_d   = valid_q;
        err_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (in_data[7:4] == SYNC) begin
                        state_d = LOAD_A;
                        cnt_d   = 2'd0;
                        to_d    = 8'd0;
                        round_d = in_data[1:0];
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            LOAD_A, LOAD_B: begin
                if (accept) begin
                    to_d  = 8'd0;
                    cnt_d = cnt_q + 2'd1;
                    if (state_q == LOAD_A) begin
                        op_a_d = {op_a_q[23:0], in_data};
                        if (cnt_q == 2'd3) state_d = LOAD_B;
                    end else begin
                        op_b_d = b_shift;
                        if (cnt_q == 2'd3) begin
                            state_d   = HOLD;
                            valid_d   = 1'b1;
                            // Classify against the B value being completed this cycle
                            special_d = (op_a_q[30:23] == 8'hFF) || (b_shift[30:23] == 8'hFF);
                        end
                    end
                end else if (!in_valid) begin
                    if (to_q == TO_LAST) begin
                        state_d = IDLE;
                        cnt_d   = 2'd0;
                        to_d    = 8'd0;
                        err_d   = 1'b1;
                    end else begin
                        to_d = to_q + 8'd1;
                    end
                end
            end
            HOLD: begin
                if (op_ready) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= 2'd0;
            to_q      <= 8'd0;
            op_a_q    <= 32'd0;
            op_b_q    <= 32'd0;
            round_q   <= 2'd0;
            special_q <= 1'b0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            to_q      <= to_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            round_q   <= round_d;
            special_q <= special_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
        end
    end

    assign op_valid   = valid_q;
    assign op_a       = op_a_q;
    assign op_b       = op_b_q;
    assign op_round   = round_q;
    assign op_special = special_q;
    assign frame_err  = err_q;

endmodule

// File: tb/tb_fpu_operand_loader.sv
// Directed bench for fpu_operand_loader: table of good frames plus hand sequences
// for stall, header reject, timeout, mid-frame reset and back-to-back consumption.
module tb_fpu_operand_loader;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        op_valid;
    logic        op_ready;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [1:0]  op_round;
    logic        op_special;
    logic        frame_err;

    int total = 0;
    int bad   = 0;

    fpu_operand_loader #(.SYNC(4'hA), .TIMEOUT(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_round  (op_round),
        .op_special(op_special),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  hdr;
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  rnd;
        logic        sp;
    } vec_t;

    vec_t vecs [5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        tick();
    endtask

    // Sends header + A + first (nb-5) B bytes; nb=9 is a full frame. Leaves in_valid low.
    task automatic send_partial(input logic [7:0] h, input logic [31:0] a,
                                input logic [31:0] b, input int nb);
        send_byte(h);
        for (int i = 0; i < 4 && i + 1 < nb; i++) send_byte(a[31-8*i -: 8]);
        for (int i = 0; i < 4 && i + 5 < nb; i++) send_byte(b[31-8*i -: 8]);
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] h, input logic [31:0] a, input logic [31:0] b);
        send_partial(h, a, b, 9);
    endtask

    task automatic chk_set(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [1:0] r, input logic sp);
        chk({tag, ".op_valid"}, 32'(op_valid), 32'd1);
        chk({tag, ".op_a"}, op_a, a);
        chk({tag, ".op_b"}, op_b, b);
        chk({tag, ".op_round"}, 32'(op_round), 32'(r));
        chk({tag, ".op_special"}, 32'(op_special), 32'(sp));
    endtask

    initial begin
        vecs[0] = '{hdr: 8'hA2, a: 32'h3F800000, b: 32'h40000000, rnd: 2'b10, sp: 1'b0};
        vecs[1] = '{hdr: 8'hA1, a: 32'h7F800000, b: 32'h3F800000, rnd: 2'b01, sp: 1'b1};
        vecs[2] = '{hdr: 8'hAF, a: 32'h00000001, b: 32'hFF800000, rnd: 2'b11, sp: 1'b1};
        vecs[3] = '{hdr: 8'hA4, a: 32'h7F7FFFFF, b: 32'h12345678, rnd: 2'b00, sp: 1'b0};
        vecs[4] = '{hdr: 8'hAC, a: 32'hC0490FDB, b: 32'h7FC00000, rnd: 2'b00, sp: 1'b1};

        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        op_ready = 1'b0;

        // Reset state
        #3;
        chk("rst.in_ready", 32'(in_ready), 32'd0);
        chk("rst.op_valid", 32'(op_valid), 32'd0);
        chk("rst.op_a", op_a, 32'd0);
        chk("rst.frame_err", 32'(frame_err), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rel.in_ready", 32'(in_ready), 32'd1);

        // Table of good frames, each consumed after one cycle of HOLD
        for (int v = 0; v < 5; v++) begin
            send_partial(vecs[v].hdr, vecs[v].a, vecs[v].b, 8);
            chk($sformatf("v%0d.pre_valid", v), 32'(op_valid), 32'd0);
            send_byte(vecs[v].b[7:0]);
            in_valid = 1'b0;
            chk_set($sformatf("v%0d", v), vecs[v].a, vecs[v].b, vecs[v].rnd, vecs[v].sp);
            chk($sformatf("v%0d.in_ready_hold", v), 32'(in_ready), 32'd0);
            chk($sformatf("v%0d.frame_err", v), 32'(frame_err), 32'd0);
            op_ready = 1'b1;
            tick();
            op_ready = 1'b0;
            chk($sformatf("v%0d.consumed", v), 32'(op_valid), 32'd0);
            chk($sformatf("v%0d.in_ready_idle", v), 32'(in_ready), 32'd1);
        end

        // Stall in HOLD for 5 cycles; a byte offered meanwhile must not be taken
        send_frame(8'hA2, 32'h3F800000, 32'h40000000);
        in_valid = 1'b1;
        in_data  = 8'hA3;
        for (int c = 0; c < 5; c++) begin
            chk_set($sformatf("stall%0d", c), 32'h3F800000, 32'h40000000, 2'b10, 1'b0);
            chk($sformatf("stall%0d.in_ready", c), 32'(in_ready), 32'd0);
            tick();
        end
        in_valid = 1'b0;
        op_ready = 1'b1;
        tick();
        op_ready = 1'b0;
        chk("stall.release_valid", 32'(op_valid), 32'd0);
        chk("stall.release_in_ready", 32'(in_ready), 32'd1);
        chk("stall.retain_a", op_a, 32'h3F800000);
        chk("stall.retain_b", op_b, 32'h40000000);

        // Header reject
        send_byte(8'h52);
        in_valid = 1'b0;
        chk("badhdr.err", 32'(frame_err), 32'd1);
        chk("badhdr.in_ready", 32'(in_ready), 32'd1);
        tick();
        chk("badhdr.err_pulse", 32'(frame_err), 32'd0);
        send_frame(8'hA3, 32'h40400000, 32'hBF800000);
        chk_set("badhdr.next", 32'h40400000, 32'hBF800000, 2'b11, 1'b0);
        op_ready = 1'b1;
        tick();
        op_ready = 1'b0;

        // Mid-frame timeout after header + 2 A bytes
        send_partial(8'hA0, 32'h11223344, 32'h0, 3);
        for (int c = 0; c < 15; c++) tick();
        chk("to.err_early", 32'(frame_err), 32'd0);
        tick();
        chk("to.err", 32'(frame_err), 32'd1);
        tick();
        chk("to.err_pulse", 32'(frame_err), 32'd0);
        chk("to.in_ready", 32'(in_ready), 32'd1);
        send_frame(8'hA0, 32'h7F800000, 32'h3F800000);
        chk_set("to.next", 32'h7F800000, 32'h3F800000, 2'b00, 1'b1);
        op_ready = 1'b1;
        tick();
        op_ready = 1'b0;

        // Asynchronous reset after the 6th byte
        send_partial(8'hA1, 32'h01020304, 32'h05060708, 6);
        chk("rst6.pre_a", op_a, 32'h01020304);
        #2;
        rst = 1'b1;
        #1;
        chk("rst6.op_a", op_a, 32'd0);
        chk("rst6.op_b", op_b, 32'd0);
        chk("rst6.op_round", 32'(op_round), 32'd0);
        chk("rst6.op_valid", 32'(op_valid), 32'd0);
        chk("rst6.in_ready", 32'(in_ready), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("rst6.rel_in_ready", 32'(in_ready), 32'd1);
        send_frame(8'hA2, 32'hC1200000, 32'h41200000);
        chk_set("rst6.next", 32'hC1200000, 32'h41200000, 2'b10, 1'b0);
        op_ready = 1'b1;
        tick();

        // op_ready tied high across two frames
        send_frame(8'hA1, 32'h3F000000, 32'h3E800000);
        chk_set("rdy.f1", 32'h3F000000, 32'h3E800000, 2'b01, 1'b0);
        tick();
        chk("rdy.f1_pulse", 32'(op_valid), 32'd0);
        chk("rdy.f1_err", 32'(frame_err), 32'd0);
        send_frame(8'hA3, 32'h7F800001, 32'h00800000);
        chk_set("rdy.f2", 32'h7F800001, 32'h00800000, 2'b11, 1'b1);
        tick();
        chk("rdy.f2_pulse", 32'(op_valid), 32'd0);
        chk("rdy.f2_err", 32'(frame_err), 32'd0);
        op_ready = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
